// File: rtl/ones_checksum_checker_pkg.sv
// ones_checksum_checker_pkg: shared widths, all-ones constant and FSM encodings
package ones_checksum_checker_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int MAX_WORDS_DEF = 15;
  localparam logic [63:0] ALL_ONES = '1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_t;
endpackage

// File: rtl/ones_checksum_checker_full_adder.sv
// full_adder: one-bit full adder cell used to build the end-around accumulator
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/ones_checksum_checker.sv
// ones_checksum_checker: accumulates a frame with ones'-complement addition and
// reports whether the result is all-ones (valid checksum) after the last beat.
module ones_checksum_checker
  import ones_checksum_checker_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             done,
  output logic             ok,
  output logic [WIDTH-1:0] sum,
  output logic             len_err
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_trunc;
  logic             r_ready;
  logic             r_done;
  logic             r_ok;
  logic [WIDTH-1:0] r_sum;
  logic             r_len_err;

  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_s1;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_full;
  logic             w_take;
  logic             w_end;

  // A fresh frame adds its first word to zero, so IDLE and ACCUM share one adder
  assign w_base = (r_state == IDLE) ? '0 : r_acc;
  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a (w_base[i]),
      .b (in_data[i]),
      .ci(w_c[i]),
      .s (w_s1[i]),
      .co(w_c[i+1])
    );
  end

  // Carry-out wraps into bit 0; the first-pass sum is at most 2^WIDTH-2, so no second carry
  assign w_acc_nxt = w_s1 + WIDTH'(w_c[WIDTH]);
  assign w_cnt_nxt = (r_state == IDLE) ? CW'(1) : r_count + CW'(1);
  assign w_full    = (w_cnt_nxt == CW'(MAX_WORDS));
  assign w_take    = in_valid && r_ready;
  assign w_end     = in_last || w_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_count   <= '0;
      r_trunc   <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_sum     <= '0;
      r_len_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: if (w_take) begin
          r_acc   <= w_acc_nxt;
          r_count <= w_cnt_nxt;
          r_trunc <= w_full && !in_last;
          r_ready <= !w_end;
          r_state <= w_end ? CHECK : ACCUM;
        end
        CHECK: begin
          r_sum     <= r_acc;
          r_ok      <= (r_acc == ALL_ONES[WIDTH-1:0]) && !r_trunc;
          r_len_err <= r_trunc;
          r_done    <= 1'b1;
          r_state   <= REPORT;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_ready;
  assign done     = r_done;
  assign ok       = r_ok;
  assign sum      = r_sum;
  assign len_err  = r_len_err;
endmodule

// File: tb/tb_ones_checksum_checker.sv
// tb_ones_checksum_checker: directed table, reset and back-to-back sequences, then
// random frames checked against a whole-frame ones'-complement reference model.
module tb_ones_checksum_checker;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       done;
  logic       ok;
  logic [3:0] sum;
  logic       len_err;

  int vecs = 0;
  int errs = 0;

  ones_checksum_checker #(.WIDTH(4), .MAX_WORDS(15)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_last (in_last),
    .done    (done),
    .ok      (ok),
    .sum     (sum),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [59:0] d;
    bit          last;
    logic [3:0]  esum;
    bit          eok;
    bit          ele;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Ones'-complement total of a frame: fold carries of the plain integer sum
  function automatic logic [3:0] fold(input int s);
    int t = s;
    while (t > 15) t = (t & 15) + (t >> 4);
    return 4'(t);
  endfunction

  task automatic send_beat(input logic [3:0] d, input bit l, input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 4'($urandom);
      in_last = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      vecs++;
      errs++;
      $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [59:0] d, input int n, input bit last, input int maxgap);
    for (int i = 0; i < n; i++) send_beat(d[4*i+:4], last && (i == n - 1), $urandom_range(0, maxgap));
  endtask

  // Called at the first negedge after the final beat was accepted
  task automatic check_result(input string tag, input logic [3:0] es, input bit eok, input bit ele);
    int pulses = 0;
    int first = -1;
    logic [3:0] s = 4'h0;
    bit o = 1'b0;
    bit l = 1'b0;
    bit r0 = 1'b1;
    bit r2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) begin
        pulses++;
        if (first < 0) begin
          first = i;
          s = sum;
          o = ok;
          l = len_err;
        end
      end
      if (i == 0) r0 = in_ready;
      if (i == 2) r2 = in_ready;
      @(negedge clk);
    end
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_latency"}, first, 1);
    chk({tag, "_sum"}, int'(s), int'(es));
    chk({tag, "_ok"}, int'(o), int'(eok));
    chk({tag, "_len_err"}, int'(l), int'(ele));
    chk({tag, "_ready_low"}, int'(r0), 0);
    chk({tag, "_ready_back"}, int'(r2), 1);
    chk({tag, "_sum_held"}, int'(sum), int'(es));
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{3,  60'h753,             1'b1, 4'hF, 1'b1, 1'b0};
    tbl[1] = '{3,  60'hB9A,             1'b1, 4'hF, 1'b1, 1'b0};
    tbl[2] = '{3,  60'h653,             1'b1, 4'hE, 1'b0, 1'b0};
    tbl[3] = '{1,  60'h0,               1'b1, 4'h0, 1'b0, 1'b0};
    tbl[4] = '{1,  60'hF,               1'b1, 4'hF, 1'b1, 1'b0};
    tbl[5] = '{15, 60'h111111111111111, 1'b0, 4'hF, 1'b0, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 4'h0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_ok", int'(ok), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_len_err", int'(len_err), 0);
    reset = 1'b0;
    chk("rst_ready_first", int'(in_ready), 1);

    for (int v = 0; v < 6; v++) begin
      send_frame(tbl[v].d, tbl[v].n, tbl[v].last, v % 3);
      check_result($sformatf("tbl%0d", v), tbl[v].esum, tbl[v].eok, tbl[v].ele);
    end

    // Partial frame aborted by reset, then a clean frame
    begin
      int pre = 0;
      send_beat(4'h3, 1'b0, 0);
      send_beat(4'h5, 1'b0, 0);
      repeat (3) begin
        if (done) pre++;
        @(negedge clk);
      end
      chk("abort_no_done", pre, 0);
      reset = 1'b1;
      #1;
      chk("async_rst_sum", int'(sum), 0);
      chk("async_rst_len_err", int'(len_err), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_ok", int'(ok), 0);
      @(negedge clk);
      reset = 1'b0;
      chk("post_rst_ready", int'(in_ready), 1);
      send_frame(60'h753, 3, 1'b1, 0);
      check_result("after_rst", 4'hF, 1'b1, 1'b0);
    end

    // Back-to-back frames with in_valid held high throughout
    begin
      logic [3:0] bd[6] = '{4'h3, 4'h5, 4'h7, 4'hA, 4'h9, 4'hB};
      bit bl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [3:0] rs[2] = '{4'h0, 4'h0};
      bit ro[2] = '{1'b0, 1'b0};
      int p = 0, dn = 0, streak = 0, gaps = 0;
      bit acc;
      for (int c = 0; c < 20; c++) begin
        if (done) begin
          if (dn < 2) begin
            rs[dn] = sum;
            ro[dn] = ok;
          end
          dn++;
        end
        if (!in_ready) streak++;
        else begin
          if (streak > 0) begin
            gaps++;
            chk("b2b_ready_low_cycles", streak, 2);
          end
          streak = 0;
        end
        in_valid = (p < 6);
        in_data  = (p < 6) ? bd[p] : 4'h0;
        in_last  = (p < 6) ? bl[p] : 1'b0;
        acc = in_valid && in_ready;
        @(negedge clk);
        if (acc) p++;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      chk("b2b_beats", p, 6);
      chk("b2b_dones", dn, 2);
      chk("b2b_gaps", gaps, 2);
      chk("b2b_sum0", int'(rs[0]), 15);
      chk("b2b_sum1", int'(rs[1]), 15);
      chk("b2b_ok0", int'(ro[0]), 1);
      chk("b2b_ok1", int'(ro[1]), 1);
    end

    // Random frames vs. whole-frame model
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(1, 15);
      bit trunc = (n == 15) && ($urandom_range(0, 2) == 0);
      logic [59:0] d = '0;
      int total = 0;
      logic [3:0] es;
      for (int i = 0; i < n; i++) d[4*i+:4] = 4'($urandom);
      if (!trunc && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n - 1; i++) total += int'(d[4*i+:4]);
        d[4*(n-1)+:4] = ~fold(total);
      end
      total = 0;
      for (int i = 0; i < n; i++) total += int'(d[4*i+:4]);
      es = fold(total);
      send_frame(d, n, !trunc, 2);
      check_result($sformatf("rnd%0d", f), es, (es == 4'hF) && !trunc, trunc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
